// File: rtl/mem_responder_pkg.sv
// Shared definitions for the load/store bus responder: funct3 codes, FSM encoding
// and the request legality check.
package mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // 1 when the request must be rejected; checks run in priority order.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       in_range);
        logic f3_ok;
        f3_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (!we) begin
            f3_ok = f3_ok || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        if (!f3_ok) begin
            return 1'b1;
        end
        if (!in_range) begin
            return 1'b1;
        end
        if (((funct3 == F3_H) || (funct3 == F3_HU)) && addr_lo[0]) begin
            return 1'b1;
        end
        if ((funct3 == F3_W) && (addr_lo != 2'b00)) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_responder_lsu_align.sv
// Little-endian lane handling: merges store data into the old word and extracts
// the sign- or zero-extended load value.
module lsu_align
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] old_word,
    input  logic [1:0]           addr_lo,
    input  logic [2:0]           funct3,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] store_word,
    output logic [WORD_SIZE-1:0] load_value
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_byte = old_word[{addr_lo, 3'b000} +: 8];
    assign load_half = old_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        store_word = old_word;
        case (funct3)
            F3_B:    store_word[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    store_word = wdata;
            default: store_word = old_word;
        endcase
    end

    always_comb begin
        load_value = '0;
        case (funct3)
            F3_B:    load_value = {{(WORD_SIZE-8){load_byte[7]}}, load_byte};
            F3_BU:   load_value = {{(WORD_SIZE-8){1'b0}}, load_byte};
            F3_H:    load_value = {{(WORD_SIZE-16){load_half[15]}}, load_half};
            F3_HU:   load_value = {{(WORD_SIZE-16){1'b0}}, load_half};
            F3_W:    load_value = old_word;
            default: load_value = '0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states, then a
// byte/half/word access on a word-organised RAM and a held response.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int RAM_SIZE    = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic                 req_we,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic [2:0]           req_funct3,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam int IDX_W = $clog2(RAM_SIZE);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WORD_SIZE-1:0] BYTE_LIMIT = WORD_SIZE'(RAM_SIZE * 4);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 wait_done;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 we_q;
    logic [2:0]           funct3_q;

    // Contents survive reset; only the power-up value is defined.
    logic [WORD_SIZE-1:0] mem [RAM_SIZE] = '{default: '0};

    logic [IDX_W-1:0]     word_idx;
    logic [WORD_SIZE-1:0] old_word;
    logic [WORD_SIZE-1:0] store_word;
    logic [WORD_SIZE-1:0] load_value;
    logic                 acc_err;

    assign word_idx  = addr_q[IDX_W+1:2];
    assign old_word  = mem[word_idx];
    assign acc_err   = access_err(we_q, funct3_q, addr_q[1:0], addr_q < BYTE_LIMIT);
    assign wait_done = (wait_cnt == CNT_W'(WAIT_CYCLES - 1));

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    lsu_align #(
        .WORD_SIZE(WORD_SIZE)
    ) u_lsu_align (
        .old_word  (old_word),
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .store_word(store_word),
        .load_value(load_value)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && req_valid) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                we_q     <= req_we;
                funct3_q <= req_funct3;
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
            end
            if (state == ST_ACCESS) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || we_q) ? '0 : load_value;
            end
        end
    end

    // An abandoned store never reaches ACCESS because reset forces IDLE at once.
    always_ff @(posedge clk) begin
        if ((state == ST_ACCESS) && we_q && !acc_err) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder against a byte-array model.
module tb_mem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int RAM_SIZE    = 1024;
    localparam int LAT         = WAIT_CYCLES + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [RAM_SIZE*4];

    always #5 clk = ~clk;

    mem_responder #(
        .WORD_SIZE  (32),
        .RAM_SIZE   (RAM_SIZE),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic we,
                                       input logic [2:0] f3);
        int n;
        if (we && f3 > 3'd2) return 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (addr >= 32'(RAM_SIZE * 4)) return 1'b1;
        n = nbytes_of(f3);
        if (addr % n != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int n;
        logic [31:0] v;
        n = nbytes_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(model_mem[int'(addr) + i]) << (8 * i));
        end
        if (!f3[2] && n < 4 && v[8*n-1]) begin
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wdata);
        int n;
        n = nbytes_of(f3);
        for (int i = 0; i < n; i++) begin
            model_mem[int'(addr) + i] = wdata[8*i +: 8];
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic wait_rsp(input string tag);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(LAT));
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                           output logic [31:0] rd, output logic err);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          guard;
        exp_err = model_err(addr, we, f3);
        exp_rd  = (exp_err || we) ? 32'd0 : model_load(addr, f3);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_we     = we;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_we     = 1'($urandom);
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        wait_rsp(tag);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " held rdata"}, rsp_rdata, exp_rd);
        end
        rd  = rsp_rdata;
        err = rsp_err;
        handshake(tag);
        if (we && !exp_err) model_store(addr, f3, wdata);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] held;
        for (int i = 0; i < RAM_SIZE * 4; i++) model_mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_txn("sw 0x10", 32'h10, 1'b1, 32'hDEADBEEF, 3'b010, 0, rd, err);
        run_txn("lw 0x10", 32'h10, 1'b0, 32'h0, 3'b010, 0, rd, err);
        check("lw 0x10 const", rd, 32'hDEADBEEF);
        run_txn("sb 0x11", 32'h11, 1'b1, 32'h000000AA, 3'b000, 0, rd, err);
        run_txn("lw after sb", 32'h10, 1'b0, 32'h0, 3'b010, 1, rd, err);
        check("lw after sb const", rd, 32'hDEADAAEF);
        run_txn("lb 0x11", 32'h11, 1'b0, 32'h0, 3'b000, 0, rd, err);
        check("lb 0x11 const", rd, 32'hFFFFFFAA);
        run_txn("lbu 0x11", 32'h11, 1'b0, 32'h0, 3'b100, 0, rd, err);
        check("lbu 0x11 const", rd, 32'h000000AA);
        run_txn("lh 0x12", 32'h12, 1'b0, 32'h0, 3'b001, 0, rd, err);
        check("lh 0x12 const", rd, 32'hFFFFDEAD);
        run_txn("lhu 0x12", 32'h12, 1'b0, 32'h0, 3'b101, 0, rd, err);
        check("lhu 0x12 const", rd, 32'h0000DEAD);
        run_txn("lh 0x13", 32'h13, 1'b0, 32'h0, 3'b001, 0, rd, err);
        check("lh 0x13 err const", 32'(err), 32'd1);
        run_txn("sw 0x11", 32'h11, 1'b1, 32'h11223344, 3'b010, 0, rd, err);
        check("sw 0x11 err const", 32'(err), 32'd1);
        run_txn("lw 0x10 unchanged", 32'h10, 1'b0, 32'h0, 3'b010, 0, rd, err);
        check("lw 0x10 unchanged const", rd, 32'hDEADAAEF);
        run_txn("lw 0x1000", 32'h1000, 1'b0, 32'h0, 3'b010, 0, rd, err);
        check("lw 0x1000 err const", 32'(err), 32'd1);
        run_txn("lw 0xffc", 32'hFFC, 1'b0, 32'h0, 3'b010, 0, rd, err);
        check("lw 0xffc err const", 32'(err), 32'd0);
        run_txn("f3 011 load", 32'h10, 1'b0, 32'h0, 3'b011, 0, rd, err);
        check("f3 011 err const", 32'(err), 32'd1);
        run_txn("f3 100 store", 32'h10, 1'b1, 32'hFFFFFFFF, 3'b100, 0, rd, err);
        check("f3 100 store err const", 32'(err), 32'd1);
        run_txn("lw after bad store", 32'h10, 1'b0, 32'h0, 3'b010, 0, rd, err);
        check("lw after bad store const", rd, 32'hDEADAAEF);

        // Backpressure with a competing request held on the bus.
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_addr   = 32'h11;
        req_funct3 = 3'b100;
        wait_rsp("bp lw");
        check("bp rdata", rsp_rdata, model_load(32'h10, 3'b010));
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp rsp_valid held", 32'(rsp_valid), 32'd1);
            check("bp rdata held", rsp_rdata, held);
            check("bp err held", 32'(rsp_err), 32'd0);
            check("bp req_ready low", 32'(req_ready), 32'd0);
        end
        handshake("bp lw");
        check("bp ready after hs", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp second accepted", 32'(req_ready), 32'd0);
        wait_rsp("bp lbu");
        check("bp lbu rdata", rsp_rdata, model_load(32'h11, 3'b100));
        handshake("bp lbu");

        // Reset while a store waits; the store must not land.
        req_valid  = 1'b1;
        req_addr   = 32'h20;
        req_we     = 1'b1;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst req_ready", 32'(req_ready), 32'd1);
        check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("async rst rsp_rdata", rsp_rdata, 32'd0);
        check("async rst rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post rst req_ready", 32'(req_ready), 32'd1);
        run_txn("lw 0x20 after rst", 32'h20, 1'b0, 32'h0, 3'b010, 0, rd, err);
        check("lw 0x20 const", rd, 32'h00000000);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = 32'hFF0 + $urandom_range(0, 31);
            else a = $urandom_range(0, 63);
            run_txn("random", a, 1'($urandom), $urandom, 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)), rd, err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
